onehot_encoder_pipe: RTL and testbench

Parametrised, registered N-to-log2(N) encoder with a valid/ready handshake on both sides. It is the successor to the fixed 8-to-3 combinational encoder:
- generalised input width;
- selectable strict one-hot or MSB-priority decoding;
- a defined error flag instead of X output;
- an output register with backpressure;
- an optional saturating error counter.

It sits between request/grant style one-hot sources and index-consuming logic.

---
 rtl/enc_pkg.sv | 12 +
 rtl/enc_core.sv | 47 ++++
 rtl/onehot_encoder_pipe.sv | 78 +++++++
 tb/tb_onehot_encoder_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and helpers for the one-hot / priority encoder pipeline.
package enc_pkg;

   localparam int ENC_MODE_STRICT = 0;
   localparam int ENC_MODE_PRIO   = 1;

   // Index width never drops below one bit, even for a two-line encoder.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/enc_core.sv
// Combinational N-to-log2(N) encoder: strict one-hot or MSB-priority decoding
// with an error flag for inputs that are illegal in the selected mode.
module enc_core
   import enc_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int MODE = ENC_MODE_STRICT,
   localparam int IW   = clog2_min1(N)
) (
   input  logic [N-1:0]  in_data,
   output logic [IW-1:0] idx,
   output logic          err
);

   logic [IW-1:0] hi_pos;
   logic          any_set;
   logic          multi_set;

   always_comb begin
      // NOTE: every variable gets a default first so no path through this block can infer a latch.
      hi_pos    = '0;
      any_set   = 1'b0;
      multi_set = 1'b0;
      idx       = '0;
      err       = 1'b1;

      // Ascending scan: the last set bit seen is the highest one.
      for (int i = 0; i < N; i++) begin
         if (in_data[i]) begin
            multi_set = multi_set | any_set;
            any_set   = 1'b1;
            hi_pos    = IW'(i);
         end
      end

      if (MODE == ENC_MODE_PRIO) begin
         if (any_set) begin
            idx = hi_pos;
            err = 1'b0;
         end
      end else if (any_set && !multi_set) begin
         idx = hi_pos;
         err = 1'b0;
      end
   end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Registered encoder with valid/ready on both sides and one output register.
// Build option: define ENC_ERR_CNT_EN to include the saturating error counter.
module onehot_encoder_pipe
   import enc_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int MODE = ENC_MODE_STRICT,
   parameter  int CW   = 8,
   localparam int IW   = clog2_min1(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_err,
   output logic          out_valid,
   input  logic          out_ready,
   input  logic          err_clr,
   output logic [CW-1:0] err_cnt
);

   logic [IW-1:0] core_idx;
   logic          core_err;
   logic          in_xfer;

   enc_core #(
      .N    (N),
      .MODE (MODE)
   ) u_core (
      .in_data (in_data),
      .idx     (core_idx),
      .err     (core_err)
   );

   // No skid buffer: accept only when the register is empty or draining now.
   assign in_ready = !out_valid || out_ready;
   assign in_xfer  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_err   <= 1'b0;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
         out_idx   <= core_idx;
         out_err   <= core_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ENC_ERR_CNT_EN
   logic [CW-1:0] cnt_q;

   // Clear has priority over a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (err_clr) begin
         cnt_q <= '0;
      end else if (in_xfer && core_err && (cnt_q != {CW{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign err_cnt = cnt_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: three instances (strict, priority, strict with
// a 2-bit counter) share one stimulus stream and are checked against a model.
module tb_onehot_encoder_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       out_ready;
   logic       err_clr;

   logic       in_ready  [3];
   logic [2:0] out_idx   [3];
   logic       out_err   [3];
   logic       out_valid [3];
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   localparam int MODE_OF [3] = '{0, 1, 0};
   localparam int CW_OF   [3] = '{8, 8, 2};

   always #5 clk = ~clk;

   onehot_encoder_pipe #(.N(8), .MODE(0), .CW(8)) dut_strict (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready[0]), .out_idx(out_idx[0]), .out_err(out_err[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .err_clr(err_clr),
      .err_cnt(cnt0)
   );

   onehot_encoder_pipe #(.N(8), .MODE(1), .CW(8)) dut_prio (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready[1]), .out_idx(out_idx[1]), .out_err(out_err[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .err_clr(err_clr),
      .err_cnt(cnt1)
   );

   onehot_encoder_pipe #(.N(8), .MODE(0), .CW(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready[2]), .out_idx(out_idx[2]), .out_err(out_err[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready), .err_clr(err_clr),
      .err_cnt(cnt2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_cnt(input int k);
      case (k)
         0:       return 32'(cnt0);
         1:       return 32'(cnt1);
         default: return 32'(cnt2);
      endcase
   endfunction

   // Counter value the build should show for a given number of illegal accepts.
   function automatic int cnt_exp(input int v);
`ifdef ENC_ERR_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   // Reference decode straight from the mode rules.
   function automatic void ref_enc(input logic [7:0] d, input int mode, output int idx, output bit err);
      int hi;
      int ones;
      hi   = 0;
      ones = $countones(d);
      for (int i = 0; i < 8; i++) if (d[i]) hi = i;
      if (ones == 0 || (mode == 0 && ones != 1)) begin
         idx = 0;
         err = 1'b1;
      end else begin
         idx = hi;
         err = 1'b0;
      end
   endfunction

   // Model state: one shared valid flag plus per-instance payload and counter.
   bit m_valid;
   int m_idx [3];
   bit m_err [3];
   int m_cnt [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0;
            m_err[k] = 1'b0;
            m_cnt[k] = 0;
         end
      end else begin
         bit accept;
         accept = in_valid && (!m_valid || out_ready);
         for (int k = 0; k < 3; k++) begin
            int  e_idx;
            bit  e_err;
            ref_enc(in_data, MODE_OF[k], e_idx, e_err);
            if (accept) begin
               m_idx[k] = e_idx;
               m_err[k] = e_err;
            end
`ifdef ENC_ERR_CNT_EN
            if (err_clr) m_cnt[k] = 0;
            else if (accept && e_err && m_cnt[k] < (1 << CW_OF[k]) - 1) m_cnt[k]++;
`endif
         end
         if (accept) m_valid = 1'b1;
         else if (out_ready) m_valid = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("model in_ready[%0d]", k), 32'(in_ready[k]), 32'(!m_valid || out_ready));
            check($sformatf("model out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid));
            if (m_valid) begin
               check($sformatf("model out_idx[%0d]", k), 32'(out_idx[k]), 32'(m_idx[k]));
               check($sformatf("model out_err[%0d]", k), 32'(out_err[k]), 32'(m_err[k]));
            end
            check($sformatf("model err_cnt[%0d]", k), get_cnt(k), 32'(m_cnt[k]));
         end
      end
   end

   // Drive one cycle of inputs, then land 2 time units after the next edge.
   task automatic cyc(input logic [7:0] d, input logic v, input logic r, input logic c);
      in_data   = d;
      in_valid  = v;
      out_ready = r;
      err_clr   = c;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      #13;
      for (int k = 0; k < 3; k++) begin
         check("reset out_valid", 32'(out_valid[k]), 0);
         check("reset out_idx", 32'(out_idx[k]), 0);
         check("reset out_err", 32'(out_err[k]), 0);
         check("reset err_cnt", get_cnt(k), 0);
         check("reset in_ready", 32'(in_ready[k]), 1);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Strict walk, back to back.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         d = 8'(1 << i);
         cyc(d, 1'b1, 1'b1, 1'b0);
         check("walk out_valid", 32'(out_valid[0]), 1);
         check("walk out_idx", 32'(out_idx[0]), 32'(i));
         check("walk out_err", 32'(out_err[0]), 0);
      end

      // Illegal strict inputs; priority instance decodes 8'h12 as 4.
      cyc(8'h00, 1'b1, 1'b1, 1'b0);
      check("strict zero idx", 32'(out_idx[0]), 0);
      check("strict zero err", 32'(out_err[0]), 1);
      cyc(8'h12, 1'b1, 1'b1, 1'b0);
      check("strict multi idx", 32'(out_idx[0]), 0);
      check("strict multi err", 32'(out_err[0]), 1);
      check("strict err_cnt", get_cnt(0), 32'(cnt_exp(2)));
      check("prio 12 idx", 32'(out_idx[1]), 4);
      check("prio 12 err", 32'(out_err[1]), 0);

      cyc(8'h81, 1'b1, 1'b1, 1'b0);
      check("prio 81 idx", 32'(out_idx[1]), 7);
      check("prio 81 err", 32'(out_err[1]), 0);
      cyc(8'h00, 1'b1, 1'b1, 1'b0);
      check("prio 00 idx", 32'(out_idx[1]), 0);
      check("prio 00 err", 32'(out_err[1]), 1);

      // Backpressure: 8'h08 held for 5 stalled cycles, then drain + reload.
      cyc(8'h08, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(8'h55, 1'b1, 1'b0, 1'b0);
         check("stall out_idx", 32'(out_idx[0]), 3);
         check("stall out_valid", 32'(out_valid[0]), 1);
         check("stall in_ready", 32'(in_ready[0]), 0);
      end
      in_data   = 8'h40;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("release in_ready", 32'(in_ready[0]), 1);
      @(posedge clk);
      #2;
      check("reload out_idx", 32'(out_idx[0]), 6);
      check("reload out_valid", 32'(out_valid[0]), 1);

      // Clear all counters.
      cyc(8'h00, 1'b0, 1'b1, 1'b1);
      check("clear err_cnt", get_cnt(0), 0);
      check("drain out_valid", 32'(out_valid[0]), 0);

      // Saturation on the 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         cyc(8'h03, 1'b1, 1'b1, 1'b0);
         check("sat err_cnt", get_cnt(2), 32'(cnt_exp((i < 3) ? i + 1 : 3)));
      end
      check("sat wide err_cnt", get_cnt(0), 32'(cnt_exp(5)));
      check("sat prio err_cnt", get_cnt(1), 0);
      cyc(8'h00, 1'b1, 1'b1, 1'b1);
      check("clear wins cnt2", get_cnt(2), 0);
      check("clear wins cnt0", get_cnt(0), 0);

      // Idle cycles with junk data are ignored.
      cyc(8'hxx, 1'b0, 1'b1, 1'b0);
      cyc(8'hxx, 1'b0, 1'b1, 1'b0);
      check("idle out_valid", 32'(out_valid[0]), 0);
      check("idle err_cnt", get_cnt(0), 0);

      // Reset between edges while a result is pending.
      cyc(8'h30, 1'b1, 1'b0, 1'b0);
      check("pre-reset prio idx", 32'(out_idx[1]), 5);
      check("pre-reset strict err", 32'(out_err[0]), 1);
      check("pre-reset err_cnt", get_cnt(0), 32'(cnt_exp(1)));
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("async out_valid", 32'(out_valid[k]), 0);
         check("async out_idx", 32'(out_idx[k]), 0);
         check("async out_err", 32'(out_err[k]), 0);
         check("async err_cnt", get_cnt(k), 0);
         check("async in_ready", 32'(in_ready[k]), 1);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Recovery after reset.
      cyc(8'h04, 1'b1, 1'b1, 1'b0);
      check("recover out_idx", 32'(out_idx[0]), 2);
      check("recover out_valid", 32'(out_valid[0]), 1);
      cyc(8'h00, 1'b0, 1'b1, 1'b0);
      check("recover drain", 32'(out_valid[0]), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
